// File: rtl/hash_pkg.sv
// Shared constants for the hash datapath and the scheduler event encoding.
// The word width, switch count and seed value are the defaults for the input selector.
package hash_pkg;

    localparam int              HASH_WORD_W     = 24;
    localparam int              HASH_SWITCH_CNT = 33;
    localparam logic [23:0]     HASH_SEED_INIT  = 24'hfe8901;

    typedef enum logic [1:0] {
        EV_NONE    = 2'd0,
        EV_RESTART = 2'd1,
        EV_ADVANCE = 2'd2
    } sched_ev_e;

    // Advance outranks restart when both counters hit in the same cycle.
    function automatic sched_ev_e decode_event(input logic restart, input logic advance);
        if (advance)
            return EV_ADVANCE;
        else if (restart)
            return EV_RESTART;
        else
            return EV_NONE;
    endfunction

endpackage

// File: rtl/mux_next_ch.sv
// Combinational search for the next enabled channel above sel, wrapping to 0.
// Channel 0 is always treated as enabled, so the search always terminates there.
module mux_next_ch #(
    parameter int N_CH = 4
) (
    input  logic [$clog2(N_CH)-1:0] sel,
    input  logic [N_CH-1:0]         ch_en,
    output logic [$clog2(N_CH)-1:0] next_sel
);

    localparam int SEL_W = $clog2(N_CH);

    logic [N_CH-1:0]  en_eff;
    logic [SEL_W-1:0] idx_sel;
    int               idx;

    assign en_eff = ch_en | N_CH'(1);

    // Walk from farthest to nearest so the nearest enabled channel is assigned last.
    always_comb begin
        next_sel = '0;
        idx      = 0;
        idx_sel  = '0;
        for (int k = N_CH - 1; k >= 1; k--) begin
            idx     = (int'(sel) + k) % N_CH;
            idx_sel = SEL_W'(idx);
            if (en_eff[idx_sel])
                next_sel = idx_sel;
        end
    end

endmodule

// File: rtl/mux_nto1_sched.sv
// Registered N-to-1 word selector whose source index is stepped by two round counters.
// dout/dout_valid/sel_o are all registers; sel changes become visible in dout one edge later.
module mux_nto1_sched
    import hash_pkg::*;
#(
    parameter int                WIDTH      = HASH_WORD_W,
    parameter int                N_CH       = 4,
    parameter int                CNT_W      = 6,
    parameter int                SWITCH_CNT = HASH_SWITCH_CNT,
    parameter logic [WIDTH-1:0]  RESET_VAL  = WIDTH'(HASH_SEED_INIT)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_CH*WIDTH-1:0]   din,
    input  logic [N_CH-1:0]         ch_en,
    input  logic [CNT_W-1:0]        counter,
    input  logic [CNT_W-1:0]        counter_2d,
    input  logic                    stall,
    output logic [WIDTH-1:0]        dout,
    output logic                    dout_valid,
    output logic [$clog2(N_CH)-1:0] sel_o
);

    localparam int SEL_W = $clog2(N_CH);

    if (N_CH < 2) begin : g_bad_nch
        $error("mux_nto1_sched: N_CH must be at least 2");
    end
    if (SWITCH_CNT < 0 || SWITCH_CNT >= (1 << CNT_W)) begin : g_bad_cnt
        $error("mux_nto1_sched: SWITCH_CNT does not fit in CNT_W bits");
    end

    logic [WIDTH-1:0] ch_word [N_CH];
    logic [SEL_W-1:0] sel;
    logic [SEL_W-1:0] next_sel;
    sched_ev_e        ev;

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        assign ch_word[k] = din[k*WIDTH +: WIDTH];
    end

    assign ev = decode_event(counter    == CNT_W'(SWITCH_CNT),
                             counter_2d == CNT_W'(SWITCH_CNT));

    mux_next_ch #(.N_CH(N_CH)) u_next (
        .sel      (sel),
        .ch_en    (ch_en),
        .next_sel (next_sel)
    );

    // dout_valid has no ready partner: stall is the only backpressure, and while it is
    // high every output holds and counter events of that cycle are dropped, not queued.
    always_ff @(posedge clk) begin
        if (reset) begin
            dout       <= RESET_VAL;
            dout_valid <= 1'b0;
            sel        <= '0;
        end else if (!stall) begin
            dout       <= ch_word[sel];
            dout_valid <= 1'b1;
            case (ev)
                EV_ADVANCE: sel <= next_sel;
                EV_RESTART: sel <= '0;
                default:    sel <= sel;
            endcase
        end
    end

    assign sel_o = sel;

endmodule
